// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: IR latch, FETCH/DECODE/EXEC/MEM/WB sequencing, watchdog, instret.
// Optional macro ILLEGAL_TRAP_EN adds a sticky TRAP state and a trap output for unknown opcodes.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    input  logic             mem_ready,
    input  logic             BrEq,
    input  logic             BrLT,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             PCSel,
    output logic [2:0]       ImmSel,
    output logic [3:0]       ALUSel,
    output logic             ASel,
    output logic             BSel,
    output logic             BrUn,
    output logic [1:0]       WBSel,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [2:0]       LoadStore_Sel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret,
`ifdef ILLEGAL_TRAP_EN
    output logic             trap,
`endif
    output logic             bus_err
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_ERR    = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Watchdog trips on the cycle its count would reach MEM_TIMEOUT.
    localparam logic [TO_W-1:0] WD_LIM = TO_W'(MEM_TIMEOUT - 1);

    state_t            state_reg;
    logic [31:0]       ir_reg;
    logic [TO_W-1:0]   wd_reg;
    logic [CNT_W-1:0]  instret_reg;
    logic              bus_err_reg;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       is_load, is_store, is_branch, is_jump, is_op, valid_op;
    logic       taken;
    logic [3:0] alu_fn;
    logic       unused_ir_bits;

    assign opcode    = ir_reg[6:0];
    assign funct3    = ir_reg[14:12];
    assign alt       = ir_reg[30];
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign is_op     = (opcode == OP_REG);
    assign valid_op  = is_load || is_store || is_branch || is_jump || is_op ||
                       (opcode == OP_IMM) || (opcode == OP_LUI) || (opcode == OP_AUIPC);
    assign unused_ir_bits = ^{ir_reg[31], ir_reg[29:15], ir_reg[11:7]};

    // Shared funct3 ALU map; IR[30] selects sub only for register ops, sra for both.
    always_comb begin
        alu_fn = 4'b0010;
        case (funct3)
            3'b000: alu_fn = (is_op && alt) ? 4'b0011 : 4'b0010;
            3'b001: alu_fn = 4'b0111;
            3'b010: alu_fn = 4'b0100;
            3'b011: alu_fn = 4'b0101;
            3'b100: alu_fn = 4'b1010;
            3'b101: alu_fn = alt ? 4'b1001 : 4'b1000;
            3'b110: alu_fn = 4'b0001;
            3'b111: alu_fn = 4'b0000;
            default: alu_fn = 4'b0010;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:          taken = BrEq;
            3'b001:          taken = !BrEq;
            3'b100, 3'b110:  taken = BrLT;
            3'b101, 3'b111:  taken = !BrLT;
            default:         taken = 1'b0;
        endcase
    end

    always_comb begin
        ImmSel = 3'b000;
        ALUSel = 4'b0010;
        ASel   = 1'b0;
        BSel   = 1'b0;
        BrUn   = 1'b0;
        WBSel  = 2'b01;
        case (opcode)
            OP_LOAD:   begin BSel = 1'b1; WBSel = 2'b00; end
            OP_STORE:  begin ImmSel = 3'b001; BSel = 1'b1; end
            OP_IMM:    begin ALUSel = alu_fn; BSel = 1'b1; end
            OP_REG:    ALUSel = alu_fn;
            OP_BRANCH: begin ImmSel = 3'b010; ASel = 1'b1; BSel = 1'b1; BrUn = funct3[2] & funct3[1]; end
            OP_JAL:    begin ImmSel = 3'b100; ASel = 1'b1; BSel = 1'b1; WBSel = 2'b10; end
            OP_JALR:   begin BSel = 1'b1; WBSel = 2'b10; end
            OP_LUI:    begin ImmSel = 3'b011; ALUSel = 4'b1011; BSel = 1'b1; end
            OP_AUIPC:  begin ImmSel = 3'b101; ASel = 1'b1; BSel = 1'b1; end
            default:   ;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: LoadStore_Sel = funct3;
            default:                                LoadStore_Sel = 3'b010;
        endcase
    end

    // Strobes are gated by rst so nothing fires while reset is held.
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        PCSel    = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = instr_valid;
                end
                ST_EXEC: begin
                    pc_we = is_branch;
                    PCSel = is_branch & taken;
                end
                ST_MEM: begin
                    MemRead  = is_load;
                    MemWrite = is_store;
                    pc_we    = is_store & mem_ready;
                end
                ST_WB: begin
                    pc_we    = 1'b1;
                    PCSel    = is_jump;
                    RegWrite = valid_op;
                end
                default: ;
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic trap_reg;
    assign trap = trap_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_FETCH;
            ir_reg      <= 32'h0000_0013;
            wd_reg      <= '0;
            instret_reg <= '0;
            bus_err_reg <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            trap_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (instr_valid) begin
                        ir_reg    <= instr;
                        wd_reg    <= '0;
                        state_reg <= ST_DECODE;
                    end else begin
                        wd_reg <= wd_reg + TO_W'(1);
                        if (wd_reg == WD_LIM) begin
                            state_reg   <= ST_ERR;
                            bus_err_reg <= 1'b1;
                        end
                    end
                end
                ST_DECODE: begin
                    wd_reg <= '0;
`ifdef ILLEGAL_TRAP_EN
                    if (!valid_op) begin
                        state_reg <= ST_TRAP;
                        trap_reg  <= 1'b1;
                    end else begin
                        state_reg <= ST_EXEC;
                    end
`else
                    state_reg <= ST_EXEC;
`endif
                end
                ST_EXEC: begin
                    if (is_branch) begin
                        instret_reg <= instret_reg + CNT_W'(1);
                        state_reg   <= ST_FETCH;
                    end else if (is_load || is_store) begin
                        state_reg <= ST_MEM;
                    end else begin
                        state_reg <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        wd_reg <= '0;
                        if (is_store) begin
                            instret_reg <= instret_reg + CNT_W'(1);
                            state_reg   <= ST_FETCH;
                        end else begin
                            state_reg <= ST_WB;
                        end
                    end else begin
                        wd_reg <= wd_reg + TO_W'(1);
                        if (wd_reg == WD_LIM) begin
                            state_reg   <= ST_ERR;
                            bus_err_reg <= 1'b1;
                        end
                    end
                end
                ST_WB: begin
                    instret_reg <= instret_reg + CNT_W'(1);
                    state_reg   <= ST_FETCH;
                end
                ST_ERR:  bus_err_reg <= 1'b1;
                ST_TRAP: ;
                default: state_reg <= ST_FETCH;
            endcase
        end
    end

    assign state   = state_reg;
    assign instret = instret_reg;
    assign bus_err = bus_err_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: decode table, hand-written corner sequences and
// randomized instruction stream checked against a per-instruction timing/strobe model.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid, mem_ready, BrEq, BrLT;
    logic        imem_req, ir_we, pc_we, PCSel;
    logic [2:0]  ImmSel;
    logic [3:0]  ALUSel;
    logic        ASel, BSel, BrUn;
    logic [1:0]  WBSel;
    logic        RegWrite, MemRead, MemWrite;
    logic [2:0]  LoadStore_Sel;
    logic [2:0]  state;
    logic [31:0] instret;
    logic        bus_err;
`ifdef ILLEGAL_TRAP_EN
    logic        trap;
`endif

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(15), .TO_W(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .mem_ready(mem_ready),
        .BrEq(BrEq), .BrLT(BrLT), .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we),
        .PCSel(PCSel), .ImmSel(ImmSel), .ALUSel(ALUSel), .ASel(ASel), .BSel(BSel), .BrUn(BrUn),
        .WBSel(WBSel), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .LoadStore_Sel(LoadStore_Sel), .state(state), .instret(instret),
`ifdef ILLEGAL_TRAP_EN
        .trap(trap),
`endif
        .bus_err(bus_err)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_instret = 0;

    typedef struct {
        logic [31:0] instr;
        int          md;
        logic        br_eq;
        logic        br_lt;
        logic [14:0] sel;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [14:0] mk(input logic [2:0] imm, input logic [3:0] alu, input logic a,
                                       input logic b, input logic u, input logic [1:0] wb,
                                       input logic [2:0] ls);
        return {imm, alu, a, b, u, wb, ls};
    endfunction

    function automatic logic [14:0] sel_now();
        return {ImmSel, ALUSel, ASel, BSel, BrUn, WBSel, LoadStore_Sel};
    endfunction

    task automatic do_reset();
        rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0; BrEq = 1'b0; BrLT = 1'b0; instr = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_instret = 0;
    endtask

    // Runs one instruction from FETCH back to FETCH; expectations come from the instruction class.
    task automatic run_instr(input logic [31:0] ins, input int fd, input int md, input logic beq,
                             input logic blt, input logic do_sel, input logic [14:0] esel,
                             input string tag);
        logic [6:0] opc;
        logic [2:0] f3;
        logic       is_ld, is_st, is_br, is_j, valid, tk, got_pcsel;
        int         e_cyc, e_rw, e_mr, e_mw;
        int         n_req, n_irwe, n_rw, n_mr, n_mw, endc;
        logic       done;
        opc   = ins[6:0];
        f3    = ins[14:12];
        is_ld = (opc == 7'h03);
        is_st = (opc == 7'h23);
        is_br = (opc == 7'h63);
        is_j  = (opc == 7'h6F) || (opc == 7'h67);
        valid = is_ld || is_st || is_br || is_j || (opc == 7'h13) || (opc == 7'h33) ||
                (opc == 7'h37) || (opc == 7'h17);
        case (f3)
            3'd0:       tk = beq;
            3'd1:       tk = !beq;
            3'd4, 3'd6: tk = blt;
            3'd5, 3'd7: tk = !blt;
            default:    tk = 1'b0;
        endcase
        e_cyc = fd + 3 + (is_br ? 0 : is_st ? md + 1 : is_ld ? md + 2 : 1);
        e_rw  = (valid && !is_st && !is_br) ? 1 : 0;
        e_mr  = is_ld ? md + 1 : 0;
        e_mw  = is_st ? md + 1 : 0;
        exp_instret = exp_instret + 1;

        n_req = 0; n_irwe = 0; n_rw = 0; n_mr = 0; n_mw = 0; endc = -1; done = 1'b0; got_pcsel = 1'b0;
        instr = ins; BrEq = beq; BrLT = blt;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            instr_valid = (cyc == fd);
            mem_ready   = (cyc == fd + 3 + md);
            #1;
            if (imem_req) n_req++;
            if (ir_we)    n_irwe++;
            if (RegWrite) n_rw++;
            if (MemRead)  n_mr++;
            if (MemWrite) n_mw++;
            if (do_sel && cyc == fd + 1) chk({tag, "_sel_decode"}, 32'(sel_now()), 32'(esel));
            if (pc_we) begin
                done = 1'b1;
                endc = cyc;
                got_pcsel = PCSel;
                if (do_sel) chk({tag, "_sel_final"}, 32'(sel_now()), 32'(esel));
            end
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        chk({tag, "_completed"}, 32'(done), 32'd1);
        chk({tag, "_cycles"}, 32'(endc + 1), 32'(e_cyc));
        chk({tag, "_pcsel"}, 32'(got_pcsel), 32'(is_br ? tk : is_j));
        chk({tag, "_regwrite_cnt"}, 32'(n_rw), 32'(e_rw));
        chk({tag, "_memread_cnt"}, 32'(n_mr), 32'(e_mr));
        chk({tag, "_memwrite_cnt"}, 32'(n_mw), 32'(e_mw));
        chk({tag, "_irwe_cnt"}, 32'(n_irwe), 32'd1);
        chk({tag, "_imemreq_cnt"}, 32'(n_req), 32'(fd + 1));
        chk({tag, "_state_end"}, 32'(state), 32'd0);
        chk({tag, "_instret"}, instret, exp_instret);
        $display("txn %s instr=%08h fd=%0d md=%0d cycles=%0d instret=%0d", tag, ins, fd, md, endc + 1, instret);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vt[$];
        logic [6:0]  ops[$];
        logic [31:0] r;

        vt.push_back('{32'h00500093, 1, 1'b0, 1'b0, mk(3'b000, 4'b0010, 1'b0, 1'b1, 1'b0, 2'b01, 3'b000)});
        vt.push_back('{32'h0000A103, 3, 1'b0, 1'b0, mk(3'b000, 4'b0010, 1'b0, 1'b1, 1'b0, 2'b00, 3'b010)});
        vt.push_back('{32'h0020A223, 2, 1'b0, 1'b0, mk(3'b001, 4'b0010, 1'b0, 1'b1, 1'b0, 2'b01, 3'b010)});
        vt.push_back('{32'h00000063, 1, 1'b0, 1'b0, mk(3'b010, 4'b0010, 1'b1, 1'b1, 1'b0, 2'b01, 3'b000)});
        vt.push_back('{32'h00007063, 1, 1'b0, 1'b0, mk(3'b010, 4'b0010, 1'b1, 1'b1, 1'b1, 2'b01, 3'b010)});
        vt.push_back('{32'h00006063, 1, 1'b0, 1'b1, mk(3'b010, 4'b0010, 1'b1, 1'b1, 1'b1, 2'b01, 3'b010)});
        vt.push_back('{32'h00001063, 1, 1'b1, 1'b0, mk(3'b010, 4'b0010, 1'b1, 1'b1, 1'b0, 2'b01, 3'b001)});
        vt.push_back('{32'h402081B3, 1, 1'b0, 1'b0, mk(3'b000, 4'b0011, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000)});
        vt.push_back('{32'h0020B1B3, 1, 1'b0, 1'b0, mk(3'b000, 4'b0101, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010)});
        vt.push_back('{32'h4020D193, 1, 1'b0, 1'b0, mk(3'b000, 4'b1001, 1'b0, 1'b1, 1'b0, 2'b01, 3'b101)});
        vt.push_back('{32'h0200D193, 1, 1'b0, 1'b0, mk(3'b000, 4'b1000, 1'b0, 1'b1, 1'b0, 2'b01, 3'b101)});
        vt.push_back('{32'h0010B193, 1, 1'b0, 1'b0, mk(3'b000, 4'b0101, 1'b0, 1'b1, 1'b0, 2'b01, 3'b010)});
        vt.push_back('{32'h0010E193, 1, 1'b0, 1'b0, mk(3'b000, 4'b0001, 1'b0, 1'b1, 1'b0, 2'b01, 3'b010)});
        vt.push_back('{32'h123452B7, 1, 1'b0, 1'b0, mk(3'b011, 4'b1011, 1'b0, 1'b1, 1'b0, 2'b01, 3'b101)});
        vt.push_back('{32'h00000297, 1, 1'b0, 1'b0, mk(3'b101, 4'b0010, 1'b1, 1'b1, 1'b0, 2'b01, 3'b000)});
        vt.push_back('{32'h000000EF, 1, 1'b0, 1'b0, mk(3'b100, 4'b0010, 1'b1, 1'b1, 1'b0, 2'b10, 3'b000)});
        vt.push_back('{32'h00008067, 1, 1'b0, 1'b0, mk(3'b000, 4'b0010, 1'b0, 1'b1, 1'b0, 2'b10, 3'b000)});
        vt.push_back('{32'h0020C1B3, 1, 1'b0, 1'b0, mk(3'b000, 4'b1010, 1'b0, 1'b0, 1'b0, 2'b01, 3'b100)});
        vt.push_back('{32'h4020D1B3, 1, 1'b0, 1'b0, mk(3'b000, 4'b1001, 1'b0, 1'b0, 1'b0, 2'b01, 3'b101)});
        vt.push_back('{32'hC0008093, 1, 1'b0, 1'b0, mk(3'b000, 4'b0010, 1'b0, 1'b1, 1'b0, 2'b01, 3'b000)});
`ifndef ILLEGAL_TRAP_EN
        vt.push_back('{32'h0000007F, 1, 1'b0, 1'b0, mk(3'b000, 4'b0010, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000)});
`endif

        // Reset values, checked asynchronously before any clock edge; ir_we must stay low under rst.
        rst = 1'b0; instr_valid = 1'b1; mem_ready = 1'b0; BrEq = 1'b0; BrLT = 1'b0; instr = 32'h0;
        #1 rst = 1'b1;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_strobes", 32'({ir_we, pc_we, RegWrite, MemRead, MemWrite}), 32'd0);
        chk("rst_nop_sel", 32'(sel_now()), 32'(mk(3'b000, 4'b0010, 1'b0, 1'b1, 1'b0, 2'b01, 3'b000)));
`ifdef ILLEGAL_TRAP_EN
        chk("rst_trap", 32'(trap), 32'd0);
`endif
        do_reset();

        // addi x1,x0,5 with instr_valid on the second FETCH cycle.
        instr = 32'h00500093;
        #1 chk("addi_c0_state", 32'(state), 32'd0);
        chk("addi_c0_imem_req", 32'(imem_req), 32'd1);
        @(posedge clk); #1;
        instr_valid = 1'b1;
        #1 chk("addi_c1_state", 32'(state), 32'd0);
        chk("addi_c1_ir_we", 32'(ir_we), 32'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        #1 chk("addi_c2_state", 32'(state), 32'd1);
        @(posedge clk); #2;
        chk("addi_c3_state", 32'(state), 32'd2);
        chk("addi_c3_pc_we", 32'(pc_we), 32'd0);
        @(posedge clk); #2;
        chk("addi_c4_state", 32'(state), 32'd4);
        chk("addi_wb_strobes", 32'({RegWrite, pc_we, PCSel}), 32'b110);
        chk("addi_wb_sel", 32'({ALUSel, BSel, WBSel}), 32'({4'b0010, 1'b1, 2'b01}));
        @(posedge clk); #1;
        exp_instret = exp_instret + 1;
        chk("addi_instret", instret, exp_instret);

        foreach (vt[i])
            run_instr(vt[i].instr, 0, vt[i].md, vt[i].br_eq, vt[i].br_lt, 1'b1, vt[i].sel, "vec");

        // Ready on the very cycle the watchdog would expire: ready wins in FETCH and MEM.
        run_instr(32'h0000A103, 14, 14, 1'b0, 1'b0, 1'b0, 15'd0, "edge_ready_wins");

        ops = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
`ifndef ILLEGAL_TRAP_EN
        ops.push_back(7'h7F);
        ops.push_back(7'h0B);
`endif
        for (int k = 0; k < 40; k++) begin
            r = $urandom();
            run_instr({r[31:7], ops[$urandom_range(0, ops.size() - 1)]}, int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'b0, 15'd0, "rand");
        end

        // Fetch watchdog: 15 idle FETCH cycles lead to ERR, sticky until rst.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            #1;
            if (i == 14) chk("wd_last_fetch_state", 32'(state), 32'd0);
            @(posedge clk); #1;
        end
        #1;
        chk("wd_err_state", 32'(state), 32'd5);
        chk("wd_bus_err", 32'(bus_err), 32'd1);
        instr_valid = 1'b1; mem_ready = 1'b1; instr = 32'h00500093;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
        end
        chk("wd_err_sticky_state", 32'(state), 32'd5);
        chk("wd_err_sticky_bus_err", 32'(bus_err), 32'd1);
        chk("wd_err_strobes", 32'({imem_req, ir_we, pc_we, RegWrite, MemRead, MemWrite}), 32'd0);
        rst = 1'b1;
        #1;
        chk("wd_async_rst_state", 32'(state), 32'd0);
        chk("wd_async_rst_bus_err", 32'(bus_err), 32'd0);
        do_reset();

        // Store aborted by rst in MEM, coincident with mem_ready.
        run_instr(32'h00500093, 0, 0, 1'b0, 1'b0, 1'b0, 15'd0, "pre_abort");
        instr = 32'h0020A223;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1 chk("abort_mem_state", 32'(state), 32'd3);
        chk("abort_memwrite", 32'(MemWrite), 32'd1);
        chk("abort_instret_before", instret, exp_instret);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("abort_pc_we", 32'(pc_we), 32'd0);
        chk("abort_memwrite_off", 32'(MemWrite), 32'd0);
        chk("abort_state", 32'(state), 32'd0);
        @(posedge clk); #1;
        chk("abort_instret", instret, 32'd0);
        do_reset();

`ifdef ILLEGAL_TRAP_EN
        instr = 32'h0000007F;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("trap_state", 32'(state), 32'd6);
            chk("trap_flag", 32'(trap), 32'd1);
            chk("trap_strobes", 32'({imem_req, pc_we, RegWrite, MemRead, MemWrite}), 32'd0);
            chk("trap_instret", instret, 32'd0);
            @(posedge clk); #1;
        end
        do_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- FSM-based control unit for the multi-cycle RV32I core; successor to the single-cycle combinational controller.
- Latches the fetched instruction into an internal IR and sequences FETCH/DECODE/EXEC/MEM/WB.
- Uses ready handshakes on instruction and data memory; drives the existing datapath selects with unchanged encodings.
- Adds a memory watchdog, a retired-instruction counter and the sltu ALU code.

Parameters:
- MEM_TIMEOUT, 15: max cycles waiting for instr_valid/mem_ready before bus error; 1..2^TO_W-1.
- TO_W, 4: watchdog counter width.
- CNT_W, 32: instret counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- instr  in  32  instruction from imem.
- instr_valid  in  1  imem data valid (ready).
- mem_ready  in  1  dmem access complete.
- BrEq  in  1  branch comparator equal.
- BrLT  in  1  branch comparator less-than.
- imem_req  out  1  fetch request.
- ir_we  out  1  IR capture strobe (informational).
- pc_we  out  1  PC update strobe.
- PCSel  out  1  0 = PC+4, 1 = ALU.
- ImmSel  out  3  I 000, S 001, B 010, U(lui) 011, J 100, U(auipc) 101.
- ALUSel  out  4  and 0000, or 0001, add 0010, sub 0011, slt 0100, sltu 0101, sll 0111, srl 1000, sra 1001, xor 1010, passB 1011.
- ASel  out  1  0 = rs1, 1 = PC.
- BSel  out  1  0 = rs2, 1 = imm.
- BrUn  out  1  unsigned compare.
- WBSel  out  2  00 mem, 01 ALU, 10 PC+4.
- RegWrite  out  1  register-file write strobe.
- MemRead  out  1  dmem read strobe.
- MemWrite  out  1  dmem write strobe.
- LoadStore_Sel  out  3  funct3 width/sign select: 000 B, 001 H, 010 W, 100 BU, 101 HU; other values map to 010.
- state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, ERR 5, TRAP 6.
- instret  out  CNT_W  retired-instruction count.
- bus_err  out  1  sticky watchdog error.

Behaviour:
Reset (async, immediate):
- state = FETCH; IR = 0x00000013 (addi x0,x0,0); instret = 0; bus_err = 0; watchdog = 0.
- All strobes (pc_we, RegWrite, MemRead, MemWrite, ir_we) = 0; imem_req = 0 during reset; selects decode from the NOP IR.

Select and strobe rules:
- Selects (ImmSel, ALUSel, ASel, BSel, BrUn, WBSel, LoadStore_Sel) are combinational on IR only, stable from DECODE through the end of the instruction.
- Strobes are asserted only in the states listed below; otherwise 0.

FETCH:
- imem_req = 1.
- On instr_valid: capture instr into IR, ir_we = 1, go to DECODE.
- Else increment watchdog; on watchdog == MEM_TIMEOUT go to ERR.

DECODE:
- Single cycle; clear watchdog; go to EXEC.

EXEC (single cycle):
- Branch (1100011): taken = beq BrEq | bne !BrEq | blt/bltu BrLT | bge/bgeu !BrLT; funct3 010/011 → not taken.
  - PCSel = taken; pc_we = 1; instret += 1; go to FETCH.
  - BrUn = 1 for funct3 110/111.
- Load/store: go to MEM.
- All other opcodes: go to WB.

MEM:
- Hold MemRead (load) or MemWrite (store) each cycle until mem_ready.
- On mem_ready:
  - Store: pc_we = 1, PCSel = 0, instret += 1, go to FETCH.
  - Load: go to WB.
- Watchdog rules as in FETCH.

WB (single cycle):
- RegWrite = 1 except for invalid opcodes; pc_we = 1; instret += 1; go to FETCH.
- PCSel = 1 for jal/jalr, else 0.
- jalr target LSB clearing is done by the datapath.

ERR:
- Terminal until rst; bus_err = 1; all strobes 0.

Datapath rules:
- sltu/sltiu → 0101.
- srai/sra chosen by IR[30], not the whole funct7.
- lui: ALUSel 1011, BSel 1.
- auipc: ASel 1, BSel 1, add.

Counter and boundaries:
- instret wraps modulo 2^CNT_W.
- mem_ready/instr_valid on the same cycle the watchdog hits MEM_TIMEOUT: ready wins.
- rst mid-MEM aborts the access with no PC or register update.

Optional Feature:
ILLEGAL_TRAP_EN:
- Defined: an opcode outside the nine RV32I classes (load, store, op-imm, op, branch, jal, jalr, lui, auipc) sends DECODE → TRAP.
  - TRAP is sticky: strobes 0, instret frozen, output port trap (1 bit, reset 0) = 1.
- Undefined: no trap port; invalid opcodes pass through EXEC → WB with RegWrite = 0, pc_we = 1 (executed as NOP) and increment instret.

Test Plan:
- Reset then instr = 0x00500093 (addi x1,x0,5), instr_valid at cycle 2 → states FETCH,FETCH,DECODE,EXEC,WB; WB: RegWrite = 1, ALUSel = 0010, BSel = 1, WBSel = 01; instret = 1.
- lw with mem_ready delayed 3 cycles → MemRead high exactly 4 MEM cycles; then WB with WBSel = 00, LoadStore_Sel = 010.
- beq, BrEq = 0 → EXEC: pc_we = 1, PCSel = 0; bgeu, BrLT = 0 → PCSel = 1, BrUn = 1; neither reaches WB.
- instr_valid held low → after 15 FETCH cycles state = 5 and bus_err = 1, unchanged until rst; rst asserted → state 0 asynchronously.
- sw with mem_ready asserted mid-way, then rst asserted in MEM → no pc_we and instret unchanged.
- Opcode 0x7F: with ILLEGAL_TRAP_EN → state 6, trap = 1; without → no register write, instret increments.
